fp_mult_seq_ctrl: RTL and testbench



---
 rtl/fp_mult_seq_ctrl_if.sv | 29 ++
 rtl/fp_mult_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fp_mult_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_seq_ctrl_if.sv
// Handshake bundle for the single-precision multiply controller.
// Input side:  in_valid/in_ready with op_a/op_b; a pair transfers on a rising
//              edge where in_valid && in_ready, and the requester holds op_a,
//              op_b and in_valid until that edge.
// Output side: out_valid/out_ready with result/flags; out_valid, result and
//              flags stay stable until a rising edge where out_valid && out_ready.
// state_dbg mirrors the controller state encoding (0 IDLE, 1 MULT, 2 NORM, 3 DONE).
interface fp_mult_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic        busy;
  logic [1:0]  state_dbg;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags, busy, state_dbg
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags, busy, state_dbg
  );
endinterface

// File: rtl/fp_mult_seq_ctrl.sv
// Sequential IEEE-754 single-precision multiply controller.
// One operation in flight: capture operands, 24-cycle shift-add mantissa
// multiply, truncating normalization, then hold the result until accepted.
// Special operands (NaN/inf/zero, denormals flushed to zero) are detected in
// the first cycle after capture and skip straight to DONE.
module fp_mult_seq_ctrl (
  input  logic              clk,
  input  logic              reset,
  fp_mult_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [47:0] mcand_q, mcand_d;   // multiplicand, shifted left each MULT cycle
  logic [23:0] mplier_q, mplier_d; // multiplier, shifted right each MULT cycle
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] prod_q, prod_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  // Operand classification from the captured fields (valid while cnt_q == 0,
  // before the mantissa registers start shifting).
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  assign a_zero  = (ea_q == 8'h00);
  assign b_zero  = (eb_q == 8'h00);
  assign a_inf   = (ea_q == 8'hFF) && (mcand_q[22:0] == 23'd0);
  assign b_inf   = (eb_q == 8'hFF) && (mplier_q[22:0] == 23'd0);
  assign a_nan   = (ea_q == 8'hFF) && (mcand_q[22:0] != 23'd0);
  assign b_nan   = (eb_q == 8'hFF) && (mplier_q[22:0] != 23'd0);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  // Biased exponent of the product, widened and signed so range checks
  // can see both overflow (>= 255) and underflow (<= 0).
  logic signed [9:0] e_raw, e_norm;
  logic [22:0]       mant;
  assign e_raw  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
  assign e_norm = prod_q[47] ? (e_raw + 10'sd1) : e_raw;
  assign mant   = prod_q[47] ? prod_q[46:24] : prod_q[45:23];

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      mcand_q     <= 48'd0;
      mplier_q    <= 24'd0;
      cnt_q       <= 5'd0;
      prod_q      <= 48'd0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      flags_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  // Next-state and datapath update for capture, multiply, normalize, hold.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d   = bus.op_a[31] ^ bus.op_b[31];
          ea_d     = bus.op_a[30:23];
          eb_d     = bus.op_b[30:23];
          mcand_d  = {24'd0, 1'b1, bus.op_a[22:0]};
          mplier_d = {1'b1, bus.op_b[22:0]};
          cnt_d    = 5'd0;
          prod_d   = 48'd0;
          state_d  = MULT;
        end
      end

      MULT: begin
        if ((cnt_q == 5'd0) && special) begin
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = 32'h7FC0_0000;
            flags_d  = 3'b100;
          end else if (a_inf || b_inf) begin
            result_d = {sign_q, 8'hFF, 23'd0};
            flags_d  = 3'b000;
          end else begin
            result_d = {sign_q, 31'd0};
            flags_d  = 3'b000;
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          prod_d   = prod_q + (mplier_q[0] ? mcand_q : 48'd0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (e_norm >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 3'b010;
        end else if (e_norm <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 3'b001;
        end else begin
          result_d = {sign_q, e_norm[7:0], mant};
          flags_d  = 3'b000;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Self-checking bench for fp_mult_seq_ctrl: directed vectors with known
// products, random finite operands against a reference multiply, plus
// backpressure, turnaround and mid-operation reset scenarios.
module tb_fp_mult_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_mult_seq_ctrl_if bus ();

  fp_mult_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];   // {flags, result}
  logic [34:0] sb_exp;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference single-precision multiply for finite, nonzero operands.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic        s;
    logic [22:0] m;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, e[7:0], m};
  endfunction

  // Pop and compare on every output transfer (sampled mid-cycle).
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check_eq("result", 64'(bus.result), 64'(sb_exp[31:0]));
        check_eq("flags", 64'(bus.flags), 64'(sb_exp[34:32]));
      end
    end
  end

  // ---------------- directed vectors ----------------
  localparam int NV = 13;
  localparam logic [31:0] VA [NV] = '{
    32'h3FC00000, 32'h3FC00000, 32'hC0000000, 32'h7F800000, 32'h7F000000,
    32'h00800000, 32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h00400000,
    32'h7F000000, 32'h00800000, 32'h00800000};
  localparam logic [31:0] VB [NV] = '{
    32'h40000000, 32'h3FC00000, 32'h40400000, 32'h00000000, 32'h7F000000,
    32'h00800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
    32'h40000000, 32'h3F800000, 32'h3F000000};
  localparam logic [34:0] VE [NV] = '{
    {3'b000, 32'h40400000}, {3'b000, 32'h40100000}, {3'b000, 32'hC0C00000},
    {3'b100, 32'h7FC00000}, {3'b010, 32'h7F800000}, {3'b001, 32'h00000000},
    {3'b100, 32'h7FC00000}, {3'b000, 32'hFF800000}, {3'b000, 32'h80000000},
    {3'b000, 32'h00000000}, {3'b010, 32'h7F800000}, {3'b000, 32'h00800000},
    {3'b001, 32'h00000000}};
  localparam int VL [NV] = '{25, 25, 25, 1, 25, 25, 1, 1, 1, 1, 25, 25, 25};

  // ---------------- driver tasks ----------------
  // Present a pair, hold it until accepted, and record the expected result.
  task automatic drive_in(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
    int t;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_in_time", 64'(t < 100), 64'd1);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
    check_eq("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  // Count edges from acceptance until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 200);
  endtask

  // With out_ready high, the edge after out_valid hands back to IDLE.
  task automatic finish_out();
    @(posedge clk); #1;
    check_eq("in_ready_after_out", 64'(bus.in_ready), 64'd1);
    check_eq("out_valid_cleared", 64'(bus.out_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [31:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_flags", 64'(bus.flags), 64'd0);
    check_eq("rst_state", 64'(bus.state_dbg), 64'd0);
    reset = 1'b0;

    // Directed vectors, consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive_in(VA[i], VB[i], VE[i]);
      wait_valid(lat);
      check_eq($sformatf("latency_v%0d", i), 64'(lat), 64'(VL[i]));
      finish_out();
    end

    // Random finite operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      drive_in(ra, rb, ref_mul(ra, rb));
      wait_valid(lat);
      check_eq("latency_rand", 64'(lat), 64'd25);
      finish_out();
    end

    // Backpressure: hold the result for 5 cycles while a new pair waits.
    bus.out_ready = 1'b0;
    drive_in(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    wait_valid(lat);
    check_eq("latency_bp", 64'(lat), 64'd25);
    bus.in_valid = 1'b1;
    bus.op_a     = 32'hC0000000;
    bus.op_b     = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_result", 64'(bus.result), 64'h40400000);
      check_eq("bp_flags", 64'(bus.flags), 64'd0);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;  // edge m: output accepted
    check_eq("turn_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("turn_not_busy", 64'(bus.busy), 64'd0);
    check_eq("turn_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("turn_result_kept", 64'(bus.result), 64'h40400000);
    @(posedge clk);      // edge m+1: waiting pair accepted
    exp_q.push_back({3'b000, 32'hC0C00000});
    #1;
    check_eq("turn_accepted", 64'(bus.busy), 64'd1);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check_eq("latency_turn", 64'(lat), 64'd25);
    finish_out();

    // Reset during MULT aborts the operation with no output.
    drive_in(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check_eq("midrst_state", 64'(bus.state_dbg), 64'd0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_in(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    wait_valid(lat);
    check_eq("latency_after_rst", 64'(lat), 64'd25);
    finish_out();

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
